// File: rtl/bat_amateur_pkg.sv
// Shared types and constants for the BatAmateur boot loader.
package bat_amateur_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_ADDR,
    HDR_COUNT,
    DATA,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

  localparam logic RAM_RW_WRITE = 1'b0;
  localparam logic RAM_RW_READ  = 1'b1;

endpackage

// File: rtl/bat_loader_checksum.sv
// Running-sum accumulator for segment checksums; the body exists only when
// BAT_LOADER_CHECKSUM_EN is defined.
`ifdef BAT_LOADER_CHECKSUM_EN
module bat_loader_checksum #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             add,
  input  logic [WIDTH-1:0] value,
  output logic             sum_zero
);

  logic [WIDTH-1:0] sum;

  // clear+add restarts the sum at the incoming word (the segment address).
  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
    end else if (add) begin
      sum <= clear ? value : sum + value;
    end
  end

  // Tests the sum including the word currently on the input, i.e. the checksum word.
  assign sum_zero = (sum + value) == '0;

endmodule
`endif

// File: rtl/bat_amateur_loader.sv
// BatAmateur boot loader: writes {address, count, data...} segments into RAM while the CPU is halted.
// Define BAT_LOADER_CHECKSUM_EN to require a checksum word after every segment.
module bat_amateur_loader #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 16,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     START,
  input  logic [DATA_WIDTH-1:0]    LOAD_DATA,
  input  logic                     LOAD_VALID,
  output logic                     LOAD_READY,
  output logic                     HALT,
  output logic                     BUS_OE,
  output logic                     RAM_EN,
  output logic                     RAM_RW,
  output logic [ADDRESS_WIDTH-1:0] ADDRESS_BUS,
  output logic [DATA_WIDTH-1:0]    DATA_BUS,
  output logic                     DONE,
  output logic                     ERROR,
  output logic [COUNT_WIDTH-1:0]   WORDS_LOADED
);
  import bat_amateur_pkg::*;

  // DONE/ERROR name both ports and states, so the states are reached by full path.
  localparam loader_state_t S_DONE = bat_amateur_pkg::DONE;
`ifdef BAT_LOADER_CHECKSUM_EN
  localparam loader_state_t S_ERROR  = bat_amateur_pkg::ERROR;
  localparam loader_state_t SEG_END  = CHECK;
  localparam loader_state_t LOAD_END = CHECK;
`else
  localparam loader_state_t SEG_END  = HDR_ADDR;
  localparam loader_state_t LOAD_END = S_DONE;
`endif

  loader_state_t            state, state_next;
  logic                     accept;
  logic                     count_zero;
  logic [ADDRESS_WIDTH-1:0] next_addr;
  logic [COUNT_WIDTH-1:0]   remaining;

  assign accept     = LOAD_VALID && LOAD_READY;
  assign count_zero = COUNT_WIDTH'(LOAD_DATA) == '0;

`ifdef BAT_LOADER_CHECKSUM_EN
  logic sum_zero;
  logic last_seg;

  bat_loader_checksum #(
    .WIDTH (DATA_WIDTH)
  ) u_checksum (
    .clk      (CLK),
    .rst      (RESET),
    .clear    (state == HDR_ADDR),
    .add      (accept),
    .value    (LOAD_DATA),
    .sum_zero (sum_zero)
  );
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, S_DONE: if (START) state_next = HDR_ADDR;
      HDR_ADDR:     if (accept) state_next = HDR_COUNT;
      HDR_COUNT:    if (accept) state_next = count_zero ? LOAD_END : DATA;
      DATA:         if (accept && remaining == COUNT_WIDTH'(1)) state_next = SEG_END;
`ifdef BAT_LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept) begin
          if (!sum_zero)     state_next = S_ERROR;
          else if (last_seg) state_next = S_DONE;
          else               state_next = HDR_ADDR;
        end
      end
`endif
      default: state_next = state;
    endcase
  end

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    LOAD_READY = 1'b0;
    HALT       = 1'b1;
    BUS_OE     = 1'b0;
    DONE       = 1'b0;
    ERROR      = 1'b0;
    case (state)
      HDR_ADDR, HDR_COUNT, DATA, CHECK: begin
        LOAD_READY = 1'b1;
        BUS_OE     = 1'b1;
      end
      S_DONE: begin
        HALT = 1'b0;
        DONE = 1'b1;
      end
`ifdef BAT_LOADER_CHECKSUM_EN
      S_ERROR: ERROR = 1'b1;
`endif
      default: ;
    endcase
  end

  // Write strobe, buses and counters: each accepted data word shows up on the bus one cycle later.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      RAM_EN       <= 1'b0;
      ADDRESS_BUS  <= '0;
      DATA_BUS     <= '0;
      WORDS_LOADED <= '0;
      next_addr    <= '0;
      remaining    <= '0;
`ifdef BAT_LOADER_CHECKSUM_EN
      last_seg     <= 1'b0;
`endif
    end else begin
      RAM_EN <= 1'b0;
      if (START && (state == IDLE || state == S_DONE)) begin
        WORDS_LOADED <= '0;
      end
      if (accept) begin
        case (state)
          HDR_ADDR: next_addr <= ADDRESS_WIDTH'(LOAD_DATA);
          HDR_COUNT: begin
            remaining <= COUNT_WIDTH'(LOAD_DATA);
`ifdef BAT_LOADER_CHECKSUM_EN
            last_seg  <= count_zero;
`endif
          end
          DATA: begin
            RAM_EN       <= 1'b1;
            ADDRESS_BUS  <= next_addr;
            DATA_BUS     <= LOAD_DATA;
            next_addr    <= next_addr + ADDRESS_WIDTH'(1);
            remaining    <= remaining - COUNT_WIDTH'(1);
            WORDS_LOADED <= WORDS_LOADED + COUNT_WIDTH'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign RAM_RW = RAM_EN ? RAM_RW_WRITE : RAM_RW_READ;

endmodule
